// File: rtl/prog_fetch.sv
// Instruction prefetch stage: drives the program ROM from a registered PC and
// buffers fetched words with their addresses in a small FIFO for decode.
module prog_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        CLK,
    input  logic        RST,
    output logic [15:0] rom_addr,
    input  logic [31:0] rom_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [15:0] instr_pc,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        halt
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [15:0]   r_pc;
    logic [31:0]   r_word [DEPTH];
    logic [15:0]   r_fpc  [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    logic w_pop;
    logic w_push;

    assign rom_addr    = r_pc;
    assign instr_valid = (r_count != '0);
    assign instr_data  = r_word[r_rd_ptr];
    assign instr_pc    = r_fpc[r_rd_ptr];

    // A full FIFO still accepts a new word when the head leaves in the same cycle.
    assign w_pop  = instr_valid & instr_ready;
    assign w_push = !redirect && !halt && ((r_count < CW'(DEPTH)) || w_pop);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pc     <= RESET_PC;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_word[i] <= '0;
                r_fpc[i]  <= '0;
            end
        end else if (redirect) begin
            r_pc     <= redirect_pc;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_word[r_wr_ptr] <= rom_data;
                r_fpc[r_wr_ptr]  <= r_pc;
                r_wr_ptr         <= r_wr_ptr + PW'(1);
                r_pc             <= r_pc + 16'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_prog_fetch.sv
// Directed bench for prog_fetch: reset, streaming, stall, redirect, wrap, halt.
module tb_prog_fetch;

    logic        CLK;
    logic        RST;
    logic [15:0] rom_addr;
    logic [31:0] rom_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [15:0] instr_pc;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halt;

    int n_checks = 0;
    int n_fail   = 0;

    prog_fetch #(.RESET_PC(16'h0000), .DEPTH(2)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_data  (instr_data),
        .instr_pc    (instr_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt)
    );

    function automatic logic [31:0] romw(input logic [15:0] a);
        return {a ^ 16'hC3A5, ~a};
    endfunction

    assign rom_data = romw(rom_addr);

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; redirect = 1'b0; redirect_pc = '0; halt = 1'b0; instr_ready = 1'b0;
        step();
        step();
        n_checks++;
        if (instr_valid !== 1'b0) begin
            $display("FAIL reset_valid got=%b exp=0", instr_valid); n_fail++;
        end
        n_checks++;
        if (instr_data !== 32'h0) begin
            $display("FAIL reset_data got=%h exp=00000000", instr_data); n_fail++;
        end
        n_checks++;
        if (instr_pc !== 16'h0) begin
            $display("FAIL reset_pc got=%h exp=0000", instr_pc); n_fail++;
        end
        n_checks++;
        if (rom_addr !== 16'h0000) begin
            $display("FAIL reset_rom_addr got=%h exp=0000", rom_addr); n_fail++;
        end
    endtask

    task automatic test_stream();
        RST = 1'b0; instr_ready = 1'b1;
        n_checks++;
        if (instr_valid !== 1'b0) begin
            $display("FAIL stream_first_cycle_valid got=%b exp=0", instr_valid); n_fail++;
        end
        step();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (instr_valid !== 1'b1 || instr_pc !== 16'(i) || instr_data !== romw(16'(i))) begin
                $display("FAIL stream_%0d got v=%b pc=%h d=%h exp v=1 pc=%h d=%h",
                         i, instr_valid, instr_pc, instr_data, 16'(i), romw(16'(i)));
                n_fail++;
            end
            step();
        end
    endtask

    task automatic test_stall();
        RST = 1'b1; instr_ready = 1'b0;
        step();
        RST = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (instr_valid !== 1'b1 || instr_pc !== 16'h0000 || instr_data !== romw(16'h0000)) begin
                $display("FAIL stall_hold_%0d got v=%b pc=%h d=%h exp v=1 pc=0000 d=%h",
                         i, instr_valid, instr_pc, instr_data, romw(16'h0000));
                n_fail++;
            end
        end
        n_checks++;
        if (rom_addr !== 16'h0002) begin
            $display("FAIL stall_pc_sat got=%h exp=0002", rom_addr); n_fail++;
        end
        instr_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (instr_valid !== 1'b1 || instr_pc !== 16'(i) || instr_data !== romw(16'(i))) begin
                $display("FAIL stall_release_%0d got v=%b pc=%h exp v=1 pc=%h",
                         i, instr_valid, instr_pc, 16'(i));
                n_fail++;
            end
            step();
        end
    endtask

    task automatic test_redirect_full();
        instr_ready = 1'b0;
        step();
        step();
        redirect = 1'b1; redirect_pc = 16'h0040; instr_ready = 1'b1;
        step();
        redirect = 1'b0;
        n_checks++;
        if (instr_valid !== 1'b0 || rom_addr !== 16'h0040) begin
            $display("FAIL redir_flush got v=%b addr=%h exp v=0 addr=0040", instr_valid, rom_addr);
            n_fail++;
        end
        step();
        n_checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 16'h0040 || instr_data !== romw(16'h0040)) begin
            $display("FAIL redir_first got v=%b pc=%h exp v=1 pc=0040", instr_valid, instr_pc);
            n_fail++;
        end
        step();
        n_checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 16'h0041) begin
            $display("FAIL redir_second got v=%b pc=%h exp v=1 pc=0041", instr_valid, instr_pc);
            n_fail++;
        end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_pc;
        exp_pc = 16'hFFFE;
        redirect = 1'b1; redirect_pc = 16'hFFFE; instr_ready = 1'b1;
        step();
        redirect = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr_data !== romw(exp_pc)) begin
                $display("FAIL wrap_%0d got v=%b pc=%h exp v=1 pc=%h", i, instr_valid, instr_pc, exp_pc);
                n_fail++;
            end
            exp_pc = exp_pc + 16'd1;
            step();
        end
    endtask

    task automatic test_back_to_back();
        redirect = 1'b1; redirect_pc = 16'h0100;
        step();
        redirect_pc = 16'h0200;
        step();
        redirect = 1'b0;
        n_checks++;
        if (instr_valid !== 1'b0) begin
            $display("FAIL b2b_flush got v=%b exp v=0", instr_valid); n_fail++;
        end
        step();
        n_checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 16'h0200) begin
            $display("FAIL b2b_target got v=%b pc=%h exp v=1 pc=0200", instr_valid, instr_pc);
            n_fail++;
        end
    endtask

    task automatic test_halt();
        instr_ready = 1'b0; redirect = 1'b1; redirect_pc = 16'h0010;
        step();
        redirect = 1'b0;
        step();
        step();
        halt = 1'b1; instr_ready = 1'b1;
        n_checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 16'h0010) begin
            $display("FAIL halt_drain0 got v=%b pc=%h exp v=1 pc=0010", instr_valid, instr_pc);
            n_fail++;
        end
        step();
        n_checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 16'h0011 || rom_addr !== 16'h0012) begin
            $display("FAIL halt_drain1 got v=%b pc=%h addr=%h exp v=1 pc=0011 addr=0012",
                     instr_valid, instr_pc, rom_addr);
            n_fail++;
        end
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if (instr_valid !== 1'b0 || rom_addr !== 16'h0012) begin
                $display("FAIL halt_empty_%0d got v=%b addr=%h exp v=0 addr=0012", i, instr_valid, rom_addr);
                n_fail++;
            end
        end
        halt = 1'b0;
        step();
        n_checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 16'h0012) begin
            $display("FAIL halt_resume got v=%b pc=%h exp v=1 pc=0012", instr_valid, instr_pc);
            n_fail++;
        end
    endtask

    task automatic test_halt_redirect();
        halt = 1'b1; redirect = 1'b1; redirect_pc = 16'h0300;
        step();
        redirect = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (instr_valid !== 1'b0 || rom_addr !== 16'h0300) begin
                $display("FAIL halt_redir_%0d got v=%b addr=%h exp v=0 addr=0300", i, instr_valid, rom_addr);
                n_fail++;
            end
            step();
        end
        halt = 1'b0;
        step();
        n_checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 16'h0300) begin
            $display("FAIL halt_redir_resume got v=%b pc=%h exp v=1 pc=0300", instr_valid, instr_pc);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid();
        instr_ready = 1'b0;
        step();
        step();
        step();
        n_checks++;
        if (instr_valid !== 1'b1 || rom_addr !== 16'h0302) begin
            $display("FAIL rstmid_full got v=%b addr=%h exp v=1 addr=0302", instr_valid, rom_addr);
            n_fail++;
        end
        RST = 1'b1; redirect = 1'b1; redirect_pc = 16'h0055;
        step();
        n_checks++;
        if (instr_valid !== 1'b0 || rom_addr !== 16'h0000 || instr_pc !== 16'h0 || instr_data !== 32'h0) begin
            $display("FAIL rstmid_state got v=%b addr=%h pc=%h d=%h exp v=0 addr=0000 pc=0000 d=00000000",
                     instr_valid, rom_addr, instr_pc, instr_data);
            n_fail++;
        end
        RST = 1'b0; redirect = 1'b0;
        step();
        n_checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 16'h0000 || instr_data !== romw(16'h0000)) begin
            $display("FAIL rstmid_first got v=%b pc=%h exp v=1 pc=0000", instr_valid, instr_pc);
            n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_full();
        test_wrap();
        test_back_to_back();
        test_halt();
        test_halt_redirect();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_fetch.md
PROG_FETCH -- requirements
Module: prog_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, meaning the program counter value loaded on reset.
REQ-002 SHALL have parameter DEPTH, default 2, meaning prefetch buffer entries; the legal values are 2 and 4.
REQ-003 SHALL have port CLK  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port rom_addr  output  16  word address driven to the program ROM.
REQ-006 SHALL have port rom_data  input  32  ROM word, combinationally valid in the same cycle as rom_addr.
REQ-007 SHALL have port instr_valid  output  1  the head instruction is presented to decode.
REQ-008 SHALL have port instr_ready  input  1  decode accepts the head instruction this cycle.
REQ-009 SHALL have port instr_data  output  32  head instruction word.
REQ-010 SHALL have port instr_pc  output  16  address the head instruction was fetched from.
REQ-011 SHALL have port redirect  input  1  branch or jump taken; flush and refetch.
REQ-012 SHALL have port redirect_pc  input  16  target address, sampled when redirect=1.
REQ-013 SHALL have port halt  input  1  suspend new fetches; buffered instructions still drain.

Function
REQ-014 SHALL drive rom_addr = pc combinationally from the registered program counter.
REQ-015 SHALL hold a FIFO of DEPTH entries {word[31:0], pc[15:0]} with a count from 0 to DEPTH.
REQ-016 SHALL define pop = instr_valid & instr_ready.
REQ-017 SHALL define push = !redirect & !halt & (count < DEPTH | pop).
- push writes {rom_data, pc}.
- push advances pc to pc+1, modulo 2^16; 16'hFFFF wraps to 16'h0000.
REQ-018 SHALL drive instr_valid = (count != 0), with instr_data and instr_pc taken from the head entry, all from registers.
REQ-019 SHALL keep instr_data and instr_pc stable while instr_valid=1 and instr_ready=0.
REQ-020 SHALL allow a simultaneous push and pop at full or non-empty count: count is unchanged and ordering is preserved.
REQ-021 SHALL set latency to 1 cycle: a word pushed at edge k is at the head, if the FIFO was empty, in the cycle after edge k.
REQ-022 SHALL sustain throughput of 1 instruction per cycle while instr_ready=1 and there is no halt or redirect.
REQ-023 SHALL handle redirect=1 as follows, taking priority over push and pop:
- count set to 0 and pointers cleared;
- pc loaded with redirect_pc;
- instr_valid low the next cycle;
- the first target instruction is valid 2 cycles after the redirect cycle.
REQ-024 SHALL update pc on redirect even when halt=1; no fetch occurs until halt falls.
REQ-025 SHALL treat back-to-back redirects as follows: the last one wins and no stale instruction is ever presented.
REQ-026 SHALL keep a pop that coincides with redirect unaccepted: the decode stage discards it.
REQ-027 SHALL handle halt=1 as follows: pc frozen, the FIFO drains normally, instr_valid falls once empty.

Reset
REQ-028 SHALL, on RST=1 at a clock edge, set:
- pc=RESET_PC;
- count=0 and pointers cleared;
- instr_valid=0, instr_data=32'h0, instr_pc=16'h0.
REQ-029 SHALL give RST priority over redirect, halt and all handshakes, including mid-stream with the FIFO full.
REQ-030 SHALL present the first instruction, at instr_pc=RESET_PC, in the second cycle after the last RST=1 cycle, given halt=0.

Verification
REQ-031 SHALL cover: reset release with instr_ready=1 and ROM words W0..W3 -> instr_pc 0,1,2,3 on consecutive cycles with data W0..W3, one per cycle.
REQ-032 SHALL cover: instr_ready=0 for 5 cycles after start -> count saturates at DEPTH, pc stops at RESET_PC+DEPTH, and the head holds pc 0; on release, pcs continue 0,1,2… with no gap or duplicate.
REQ-033 SHALL cover: redirect with redirect_pc=16'h0040 while the FIFO is full -> instr_valid=0 next cycle, then instr_pc=16'h0040 two cycles after, followed by 16'h0041.
REQ-034 SHALL cover: redirect to 16'hFFFE with instr_ready=1 -> instr_pc sequence FFFE, FFFF, 0000, 0001.
REQ-035 SHALL cover: halt=1 with 2 entries buffered and instr_ready=1 -> 2 instructions delivered, then instr_valid=0 and rom_addr constant; deassert halt -> fetch resumes at the next sequential pc.
REQ-036 SHALL cover: RST=1 asserted mid-stream with the FIFO full and redirect=1 the same cycle -> the next cycle shows pc=RESET_PC and instr_valid=0; redirect_pc is ignored.
